vec_decode_execute: RTL and testbench



---
 rtl/vec_decode_execute.sv | 137 +++++++++++++
 tb/tb_vec_decode_execute.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vec_decode_execute.sv
// vec_decode_execute: decode/execute core for the lane-parallel vector CPU.
// Decodes the 7-bit instruction id into pipeline controls, runs the
// lane-parallel ALU with Z/C status, forms the 32-bit effective address,
// and holds the only architectural state: the registered flags.
// Optional feature macro: ALU_SHIFT_EN (enables SHL/SHR; when undefined the
// shift opcodes return all-zero lanes with Z=1, C=0).
module vec_decode_execute #(
   parameter int R = 6,
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [6:0]     Id,
   output logic           RegWrite,
   output logic           MemtoReg,
   output logic           MemWrite,
   output logic           FlagsWrite,
   output logic           RegSrc,
   output logic [1:0]     VSIFlag,
   output logic           LDFlag,
   output logic [2:0]     ALUControl,
   input  logic [R*N-1:0] SrcAE,
   input  logic [R*N-1:0] SrcBE,
   input  logic [N-1:0]   ImmE,
   input  logic [1:0]     VSIFlagE,
   input  logic [2:0]     ALUControlE,
   input  logic           FlagsWriteE,
   output logic [R*N-1:0] ALUOutputE,
   output logic [1:0]     ALUFlagsE,
   output logic [31:0]    AddressE,
   output logic [1:0]     FlagsQ
);

   logic [N-1:0] w_b   [R];
   logic [N:0]   w_res [R];
   logic [1:0]   r_flags;

   // One lane of the ALU: returns {carry/borrow, result}.
   function automatic logic [N:0] f_lane(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic [2:0]   op);
      logic [N:0] r;
      r = '0;
      case (op)
         3'b000:         r = {1'b0, a} + {1'b0, b};
         3'b001, 3'b111: r = {(a < b), a - b};
         3'b010:         r = {1'b0, a & b};
         3'b011:         r = {1'b0, a | b};
         3'b100:         r = {1'b0, a ^ b};
`ifdef ALU_SHIFT_EN
         3'b101:         r = {1'b0, a << b[2:0]};
         3'b110:         r = {1'b0, a >> b[2:0]};
`else
         3'b101, 3'b110: r = '0;
`endif
         default:        r = '0;
      endcase
      return r;
   endfunction

   // Instruction decode into pipeline control signals.
   always_comb begin
      RegWrite   = 1'b0;
      MemtoReg   = 1'b0;
      MemWrite   = 1'b0;
      FlagsWrite = 1'b0;
      RegSrc     = 1'b0;
      VSIFlag    = 2'b00;
      LDFlag     = 1'b0;
      ALUControl = 3'b000;
      case (Id[6:5])
         2'b01: begin
            ALUControl = Id[4:2];
            VSIFlag    = Id[1:0];
            FlagsWrite = 1'b1;
            RegWrite   = (Id[4:2] != 3'b111);
         end
         2'b10: begin
            VSIFlag = {1'b0, Id[3]};
            if (!Id[4]) begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               LDFlag   = 1'b1;
            end else begin
               MemWrite = 1'b1;
               RegSrc   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // B operand selection per lane; scalar-immediate mode uses ImmE.
   always_comb begin
      for (int l = 0; l < R; l++) begin
         case (VSIFlagE)
            2'b00:   w_b[l] = SrcBE[l*N +: N];
            2'b01:   w_b[l] = SrcBE[N-1:0];
            default: w_b[l] = ImmE;
         endcase
      end
   end

   // Lane-parallel ALU evaluation.
   always_comb begin
      for (int l = 0; l < R; l++) begin
         w_res[l] = f_lane(SrcAE[l*N +: N], w_b[l], ALUControlE);
      end
   end

   // Collect active lanes into the result bus and reduce Z/C over them.
   always_comb begin
      ALUOutputE = '0;
      ALUFlagsE  = 2'b10;
      for (int l = 0; l < R; l++) begin
         if (VSIFlagE != 2'b11 || l == 0) begin
            ALUOutputE[l*N +: N] = w_res[l][N-1:0];
            if (w_res[l][N-1:0] != '0) ALUFlagsE[1] = 1'b0;
            if (w_res[l][N])           ALUFlagsE[0] = 1'b1;
         end
      end
   end

   // Effective address: low four lanes form the 32-bit base, lane 3 on top.
   always_comb begin
      AddressE = SrcAE[31:0] + 32'(ImmE);
   end

   // Architectural flags register; reset dominates the write enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            r_flags <= 2'b00;
      else if (FlagsWriteE) r_flags <= ALUFlagsE;
   end

   assign FlagsQ = r_flags;

endmodule

// File: tb/tb_vec_decode_execute.sv
// Testbench for vec_decode_execute: directed checks plus randomized ALU and
// flags-register traffic compared against an arithmetic reference model.
module tb_vec_decode_execute;

   localparam int R = 6;
   localparam int N = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [6:0]     Id;
   logic           RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc, LDFlag;
   logic [1:0]     VSIFlag;
   logic [2:0]     ALUControl;
   logic [R*N-1:0] SrcAE, SrcBE;
   logic [N-1:0]   ImmE;
   logic [1:0]     VSIFlagE;
   logic [2:0]     ALUControlE;
   logic           FlagsWriteE;
   logic [R*N-1:0] ALUOutputE;
   logic [1:0]     ALUFlagsE;
   logic [31:0]    AddressE;
   logic [1:0]     FlagsQ;

   int n_cmp = 0;
   int n_err = 0;

   vec_decode_execute #(.R(R), .N(N)) dut (
      .clk(clk), .reset(reset), .Id(Id),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
      .FlagsWrite(FlagsWrite), .RegSrc(RegSrc), .VSIFlag(VSIFlag),
      .LDFlag(LDFlag), .ALUControl(ALUControl),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .ImmE(ImmE), .VSIFlagE(VSIFlagE),
      .ALUControlE(ALUControlE), .FlagsWriteE(FlagsWriteE),
      .ALUOutputE(ALUOutputE), .ALUFlagsE(ALUFlagsE),
      .AddressE(AddressE), .FlagsQ(FlagsQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] dec_vec();
      return {RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc, VSIFlag, LDFlag, ALUControl};
   endfunction

   // {RegWrite,MemtoReg,MemWrite,FlagsWrite,RegSrc,VSIFlag,LDFlag,ALUControl}
   function automatic logic [10:0] dec_model(input logic [6:0] id);
      logic [2:0] op;
      op = id[4:2];
      if (id[6:5] == 2'b01)
         return {(op != 3'd7), 1'b0, 1'b0, 1'b1, 1'b0, id[1:0], 1'b0, op};
      if (id[6:5] == 2'b10 && !id[4])
         return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, id[3], 1'b1, 3'b000};
      if (id[6:5] == 2'b10 && id[4])
         return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, id[3], 1'b0, 3'b000};
      return 11'd0;
   endfunction

   // Reference ALU using plain integer arithmetic.
   function automatic void alu_model(input logic [47:0] a, input logic [47:0] b,
                                     input logic [7:0] imm, input logic [1:0] m,
                                     input logic [2:0] op,
                                     output logic [47:0] out, output logic [1:0] fl);
      int av, bv, r;
      bit z, c;
      z = 1; c = 0; out = '0;
      for (int l = 0; l < 6; l++) begin
         if (m == 2'b11 && l > 0) break;
         av = int'(a[l*8 +: 8]);
         if (m == 2'b00)      bv = int'(b[l*8 +: 8]);
         else if (m == 2'b01) bv = int'(b[7:0]);
         else                 bv = int'(imm);
         r = 0;
         case (op)
            3'd0: begin r = av + bv; if (r > 255) c = 1; end
            3'd1, 3'd7: begin r = av - bv; if (av < bv) c = 1; end
            3'd2: r = av & bv;
            3'd3: r = av | bv;
            3'd4: r = av ^ bv;
`ifdef ALU_SHIFT_EN
            3'd5: r = av * (1 << (bv % 8));
            3'd6: r = av / (1 << (bv % 8));
`endif
            default: r = 0;
         endcase
         r = r & 255;
         out[l*8 +: 8] = r[7:0];
         if (r != 0) z = 0;
      end
      fl = {z, c};
   endfunction

   logic [47:0] e_out;
   logic [1:0]  e_fl;
   logic [1:0]  e_q;
   logic [31:0] e_addr;

   initial begin
      reset = 1'b1; Id = '0; SrcAE = '0; SrcBE = '0; ImmE = '0;
      VSIFlagE = 2'b00; ALUControlE = 3'b000; FlagsWriteE = 1'b0;
      #1;
      chk("reset_flagsq", FlagsQ, 2'b00);
      @(negedge clk); reset = 1'b0;

      // Directed decode
      Id = 7'b0110011; #1;
      chk("dec_xor_si", dec_vec(), 11'b1_0_0_1_0_11_0_100);
      Id = 7'b1000000; #1;
      chk("dec_ld", dec_vec(), 11'b1_1_0_0_0_00_1_000);
      Id = 7'b1010000; #1;
      chk("dec_str", dec_vec(), 11'b0_0_1_0_1_00_0_000);
      Id = 7'b0111100; #1;
      chk("dec_cmp", dec_vec(), 11'b0_0_0_1_0_00_0_111);
      // Exhaustive decode against the rule model
      for (int i = 0; i < 128; i++) begin
         Id = 7'(i); #1;
         chk("dec_all", dec_vec(), dec_model(Id));
      end

      // ADD overflow in every lane, then latch flags
      @(negedge clk);
      SrcAE = {6{8'd200}}; SrcBE = {6{8'd100}}; VSIFlagE = 2'b00;
      ALUControlE = 3'b000; FlagsWriteE = 1'b1; #1;
      chk("add_out", ALUOutputE, {6{8'd44}});
      chk("add_flags", ALUFlagsE, 2'b01);
      @(posedge clk); #1;
      FlagsWriteE = 1'b0;
      chk("add_flagsq", FlagsQ, 2'b01);

      // XOR scalar immediate
      @(negedge clk);
      SrcAE = {$urandom(), $urandom()}; SrcAE[7:0] = 8'd5; ImmE = 8'd1;
      VSIFlagE = 2'b11; ALUControlE = 3'b100; #1;
      chk("xor_si_out", ALUOutputE, 48'h0000_0000_0004);
      chk("xor_si_flags", ALUFlagsE, 2'b00);
      @(posedge clk); #1;
      chk("flagsq_hold", FlagsQ, 2'b01);

      // Address forming and wrap
      @(negedge clk);
      SrcAE = 48'h1234_FFFF_FFFC; ImmE = 8'd4; #1;
      chk("addr_wrap", AddressE, 32'h0000_0000);
      SrcAE = 48'hABCD_0000_1000; #1;
      chk("addr_plain", AddressE, 32'h0000_1004);

      // Randomized ALU/address/flags traffic
      e_q = FlagsQ;
      for (int it = 0; it < 400; it++) begin
         @(negedge clk); #1;
         chk("rand_flagsq", FlagsQ, e_q);
         SrcAE = {$urandom(), $urandom()};
         SrcBE = {$urandom(), $urandom()};
         if ($urandom_range(0, 3) == 0) SrcBE = SrcAE;
         ImmE = 8'($urandom());
         VSIFlagE = 2'($urandom_range(0, 3));
         ALUControlE = 3'($urandom_range(0, 7));
         FlagsWriteE = 1'($urandom_range(0, 1));
         #1;
         alu_model(SrcAE, SrcBE, ImmE, VSIFlagE, ALUControlE, e_out, e_fl);
         e_addr = 32'(64'(SrcAE[31:0]) + 64'(ImmE));
         chk("rand_out", ALUOutputE, e_out);
         chk("rand_flags", ALUFlagsE, e_fl);
         chk("rand_addr", AddressE, e_addr);
         if (FlagsWriteE) e_q = e_fl;
      end

      // Reach FlagsQ=11, then async reset between edges
      @(negedge clk);
      SrcAE = {6{8'h80}}; SrcBE = {6{8'h80}}; VSIFlagE = 2'b00;
      ALUControlE = 3'b000; FlagsWriteE = 1'b1;
      @(posedge clk); #1;
      FlagsWriteE = 1'b0;
      chk("flagsq_11", FlagsQ, 2'b11);
      #1 reset = 1'b1;
      #1;
      chk("async_reset", FlagsQ, 2'b00);

      // Reset dominates a concurrent flags write
      @(negedge clk);
      SrcAE = {6{8'd3}}; SrcBE = {6{8'd3}}; ALUControlE = 3'b001; FlagsWriteE = 1'b1; #1;
      chk("sub_eq_flags", ALUFlagsE, 2'b10);
      @(posedge clk); #1;
      chk("reset_wins", FlagsQ, 2'b00);
      @(negedge clk); reset = 1'b0; FlagsWriteE = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_hold", FlagsQ, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
